// File: rtl/adc128s_pkg.sv
// Shared widths, channel map and helpers for the ADC128S SPI converter model.
// Optional dithering is enabled with the ADC128S_DITHER_EN macro.
package adc128s_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned LFSR_W  = 16;

   // Channel address field position inside a received frame
   localparam int unsigned CH_MSB = 13;
   localparam int unsigned CH_LSB = 11;

   typedef logic [CH_W-1:0] ch_t;

   localparam ch_t CH_LFT   = 3'd0;
   localparam ch_t CH_RGHT  = 3'd4;
   localparam ch_t CH_STEER = 3'd5;
   localparam ch_t CH_BATT  = 3'd6;

   localparam logic [DATA_W-1:0] UNUSED_VAL = 12'h000;
   localparam logic [CNT_W-1:0]  FRAME_BITS = 5'd16;
   localparam logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1;

   // One step of the 16-bit Fibonacci LFSR, taps 16,15,13,4
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
   endfunction

endpackage

// File: rtl/adc_spi_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses on the synchronised
// SS_n and SCLK. Pulses are combinational (_c) from the registered copies.
module adc_spi_sync
   import adc128s_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic SCLK,
   input  logic MOSI,
   output logic ss_n_s,
   output logic mosi_s,
   output logic ss_fall_c,
   output logic ss_rise_c,
   output logic sclk_rise_c
);

   logic ss_meta;
   logic ss_prev;
   logic sclk_meta;
   logic sclk_sync;
   logic sclk_prev;
   logic mosi_meta;

   // Flops reset to the idle bus state so no spurious edge follows reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_meta   <= 1'b1;
         ss_n_s    <= 1'b1;
         ss_prev   <= 1'b1;
         sclk_meta <= 1'b1;
         sclk_sync <= 1'b1;
         sclk_prev <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         ss_meta   <= SS_n;
         ss_n_s    <= ss_meta;
         ss_prev   <= ss_n_s;
         sclk_meta <= SCLK;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         mosi_meta <= MOSI;
         mosi_s    <= mosi_meta;
      end
   end

   assign ss_fall_c   =  ss_prev   & ~ss_n_s;
   assign ss_rise_c   = ~ss_prev   &  ss_n_s;
   assign sclk_rise_c = ~sclk_prev &  sclk_sync;

endmodule

// File: rtl/adc128s_model.sv
// Behavioural 8-channel 12-bit SPI A2D model: each frame returns the channel
// addressed by the previous valid frame. ADC128S_DITHER_EN adds 1-LSB LFSR noise.
module adc128s_model
   import adc128s_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] ld_cell_lft,
   input  logic [DATA_W-1:0] ld_cell_rght,
   input  logic [DATA_W-1:0] steerPot,
   input  logic [DATA_W-1:0] batt,
   output logic              update_ch
);

   logic ss_n_s;
   logic mosi_s;
   logic ss_fall_c;
   logic ss_rise_c;
   logic sclk_rise_c;

   ch_t                ch_ptr;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   bit_cnt;

   logic [DATA_W-1:0]  sample_raw_c;
   logic [DATA_W-1:0]  sample_c;
   logic [FRAME_W-1:0] shreg_nxt_c;
   logic [CNT_W-1:0]   cnt_nxt_c;
   logic               frame_ok_c;

   adc_spi_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .SS_n        (SS_n),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .ss_n_s      (ss_n_s),
      .mosi_s      (mosi_s),
      .ss_fall_c   (ss_fall_c),
      .ss_rise_c   (ss_rise_c),
      .sclk_rise_c (sclk_rise_c)
   );

   // Channel mux
   always_comb begin
      sample_raw_c = UNUSED_VAL;
      case (ch_ptr)
         CH_LFT:   sample_raw_c = ld_cell_lft;
         CH_RGHT:  sample_raw_c = ld_cell_rght;
         CH_STEER: sample_raw_c = steerPot;
         CH_BATT:  sample_raw_c = batt;
         default:  sample_raw_c = UNUSED_VAL;
      endcase
   end

`ifdef ADC128S_DITHER_EN
   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else if (frame_ok_c)
         lfsr <= lfsr_step(lfsr);
   end

   assign sample_c = sample_raw_c ^ DATA_W'(lfsr[0]);
`else
   assign sample_c = sample_raw_c;
`endif

   // SCLK edge is applied before the frame-end check, so a coincident SS_n rise
   // still sees the last bit; edges after the 16th are dropped entirely.
   always_comb begin
      shreg_nxt_c = shreg;
      cnt_nxt_c   = bit_cnt;
      if (sclk_rise_c && (!ss_n_s || ss_rise_c) && (bit_cnt != FRAME_BITS)) begin
         shreg_nxt_c = {shreg[FRAME_W-2:0], mosi_s};
         cnt_nxt_c   = bit_cnt + CNT_W'(1);
      end
      frame_ok_c = ss_rise_c && (cnt_nxt_c == FRAME_BITS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_ptr    <= CH_LFT;
         shreg     <= '0;
         bit_cnt   <= '0;
         update_ch <= 1'b0;
      end else begin
         update_ch <= frame_ok_c;
         if (ss_fall_c) begin
            shreg   <= {{(FRAME_W-DATA_W){1'b0}}, sample_c};
            bit_cnt <= '0;
         end else begin
            shreg   <= shreg_nxt_c;
            bit_cnt <= cnt_nxt_c;
         end
         if (frame_ok_c)
            ch_ptr <= shreg_nxt_c[CH_MSB:CH_LSB];
      end
   end

   assign MISO = ss_n_s ? 1'bz : shreg[FRAME_W-1];

endmodule

// File: tb/tb_adc128s_model.sv
// Directed bench for adc128s_model: channel addressing, aborted and overlong
// frames, mid-frame input changes and (with ADC128S_DITHER_EN) dither range.
module tb_adc128s_model;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [11:0] ld_cell_lft;
   logic [11:0] ld_cell_rght;
   logic [11:0] steerPot;
   logic [11:0] batt;
   logic        update_ch;

   int n_assert = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;

`ifdef ADC128S_DITHER_EN
   localparam logic [15:0] RX_MASK = 16'hFFFE;
`else
   localparam logic [15:0] RX_MASK = 16'hFFFF;
`endif

   adc128s_model dut (
      .clk          (clk),
      .rst          (rst),
      .SS_n         (SS_n),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .ld_cell_lft  (ld_cell_lft),
      .ld_cell_rght (ld_cell_rght),
      .steerPot     (steerPot),
      .batt         (batt),
      .update_ch    (update_ch)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (update_ch === 1'b1) upd_cnt++;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rx(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      chk(tag, obs & RX_MASK, exp & RX_MASK);
   endtask

   // Master: drive MOSI while SCLK low, sample MISO on the SCLK rise
   task automatic frame(input logic [15:0] tx, input int nbits, input int chg_bit,
                        input logic [11:0] new_batt, output logic [15:0] rx);
      rx = '0;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? tx[15-i] : 1'b1;
         if (i == chg_bit) batt = new_batt;
         repeat (HALF) @(negedge clk);
         rx = {rx[14:0], MISO};
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      SS_n = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   initial begin
      logic [15:0] rx;
      int          up0;
      int          bad;
      bit          seen0, seen1;

      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      ld_cell_lft = 12'hABC; ld_cell_rght = 12'h123;
      steerPot = 12'h800; batt = 12'hFFF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      n_assert++;
      assert (MISO === 1'bz) else begin
         n_fail++;
         $error("FAIL reset_miso observed=%b expected=z", MISO);
      end
      chk("reset_update", 16'(update_ch), 16'h0000);
      chk("reset_ch_ptr", 16'(dut.ch_ptr), 16'h0000);

      // Channel 0 after reset
      up0 = upd_cnt;
      frame(16'h0000, 16, -1, 12'h000, rx);
      chk_rx("frame_ch0", rx, 16'h0ABC);
      chk("upd_ch0", 16'(upd_cnt - up0), 16'd1);
      n_assert++;
      assert (MISO === 1'bz) else begin
         n_fail++;
         $error("FAIL idle_miso observed=%b expected=z", MISO);
      end

      // Address ch4, then read it
      frame(16'h2000, 16, -1, 12'h000, rx);
      chk_rx("addr_ch4_rx", rx, 16'h0ABC);
      chk("ch_ptr_4", 16'(dut.ch_ptr), 16'h0004);
      frame(16'h0000, 16, -1, 12'h000, rx);
      chk_rx("frame_ch4", rx, 16'h0123);

      // ch5 then ch6
      frame(16'h2800, 16, -1, 12'h000, rx);
      chk_rx("addr_ch5_rx", rx, 16'h0ABC);
      up0 = upd_cnt;
      frame(16'h3000, 16, -1, 12'h000, rx);
      chk_rx("frame_ch5", rx, 16'h0800);
      frame(16'h3000, 16, -1, 12'h000, rx);
      chk_rx("frame_ch6", rx, 16'h0FFF);
      chk("upd_two_frames", 16'(upd_cnt - up0), 16'd2);

      // Aborted frame leaves pointer at ch6
      up0 = upd_cnt;
      frame(16'h1000, 9, -1, 12'h000, rx);
      chk("abort_no_update", 16'(upd_cnt - up0), 16'd0);
      chk("abort_ch_ptr", 16'(dut.ch_ptr), 16'h0006);
      frame(16'h1000, 16, -1, 12'h000, rx);
      chk_rx("after_abort", rx, 16'h0FFF);

      // Unused channel, then mid-frame input change
      frame(16'h3000, 16, -1, 12'h000, rx);
      chk_rx("frame_ch2", rx, 16'h0000);
      frame(16'h0000, 16, 5, 12'h123, rx);
      chk_rx("midframe_batt", rx, 16'h0FFF);

      // Extra SCLK edges beyond 16 are ignored; address stays from the first 16 bits
      up0 = upd_cnt;
      frame(16'h2800, 18, -1, 12'h000, rx);
      chk("long_update", 16'(upd_cnt - up0), 16'd1);
      chk("long_ch_ptr", 16'(dut.ch_ptr), 16'h0005);
      frame(16'h0000, 16, -1, 12'h000, rx);
      chk_rx("long_next", rx, 16'h0800);

`ifdef ADC128S_DITHER_EN
      batt = 12'h800;
      frame(16'h3000, 16, -1, 12'h000, rx);
      bad = 0; seen0 = 1'b0; seen1 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         frame(16'h3000, 16, -1, 12'h000, rx);
         if (rx == 16'h0800) seen0 = 1'b1;
         else if (rx == 16'h0801) seen1 = 1'b1;
         else bad++;
      end
      chk("dither_range", 16'(bad), 16'd0);
      chk("dither_seen_800", 16'(seen0), 16'd1);
      chk("dither_seen_801", 16'(seen1), 16'd1);
`else
      bad = 0; seen0 = 1'b0; seen1 = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
